// File: rtl/display_pkg.sv
// Shared types and segment encoding for the front-panel display output stage.
//   disp_mode_t : display mode FSM encoding (LIVE / PEEK / RESULT)
//   SEG_BLANK   : all segments off (active-low)
//   hex_to_seg  : 4-bit nibble -> active-low 7-seg pattern, segment a..g = bit0..bit6
package display_pkg;

    typedef enum logic [1:0] {
        DISP_LIVE   = 2'd0,
        DISP_PEEK   = 2'd1,
        DISP_RESULT = 2'd2
    } disp_mode_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low hex glyphs; bit0 = segment a ... bit6 = segment g
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] seg;
        unique case (nibble)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/hex7_seg_decoder.sv
// Combinational hex digit decoder.
//   nibble : 4-bit value to show
//   seg_c  : active-low segments, a..g = bit0..bit6
module hex7_seg_decoder
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_c
);

    assign seg_c = hex_to_seg(nibble);

endmodule

// File: rtl/display_output_ctrl.sv
// Front-panel output stage: bus LEDs, hex digits of the datapath value, a
// timestep digit and a done LED, all registered. A mode FSM (LIVE/PEEK/RESULT)
// snapshots reg_val when done rises and holds it on the digits.
// Optional feature macro: DONE_BLINK_EN (done LED blinks every BLINK_HALF cycles).
// Ports:
//   clk, resetn  : clock, synchronous active-low reset
//   bus          : processor bus value (DATA_W)
//   reg_val      : selected register value (DATA_W)
//   time_step    : controller timestep (TIME_W)
//   peek_n       : active-low request to show bus instead of register
//   done         : instruction-complete flag
//   led_bus      : registered copy of bus
//   hex_data     : NUM_DIGITS active-low digits, digit 0 = LS nibble at [6:0]
//   hex_time     : active-low timestep digit
//   led_done_n   : active-low done LED
//   mode         : current FSM state
module display_output_ctrl
    import display_pkg::*;
#(
    parameter int unsigned DATA_W     = 10,
    parameter int unsigned TIME_W     = 2,
    parameter int unsigned BLINK_HALF = 25_000_000
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic [DATA_W-1:0]               bus,
    input  logic [DATA_W-1:0]               reg_val,
    input  logic [TIME_W-1:0]               time_step,
    input  logic                            peek_n,
    input  logic                            done,
    output logic [DATA_W-1:0]               led_bus,
    output logic [((DATA_W+3)/4)*7-1:0]     hex_data,
    output logic [6:0]                      hex_time,
    output logic                            led_done_n,
    output logic [1:0]                      mode
);

    localparam int unsigned NUM_DIGITS = (DATA_W + 3) / 4;
    localparam int unsigned PAD_W      = NUM_DIGITS * 4;

    // Elaboration-time parameter sanity checks
    if (TIME_W == 0 || TIME_W > 4) begin : g_bad_time_w
        $error("display_output_ctrl: TIME_W must be 1..4");
    end
    if (BLINK_HALF == 0) begin : g_bad_blink_half
        $error("display_output_ctrl: BLINK_HALF must be nonzero");
    end

    disp_mode_t              state_q;
    disp_mode_t              state_next;
    logic                    done_q;
    logic                    done_rise_c;
    logic [DATA_W-1:0]       snapshot_q;
    logic [DATA_W-1:0]       disp_val_c;
    logic [PAD_W-1:0]        disp_pad_c;
    logic [3:0]              time_pad_c;
    logic [NUM_DIGITS*7-1:0] seg_data_c;
    logic [6:0]              seg_time_c;

    assign done_rise_c = done & ~done_q;
    assign mode        = state_q;

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= DISP_LIVE;
        end else begin
            state_q <= state_next;
        end
    end

    // Next-state: peek request always wins
    always_comb begin
        state_next = state_q;
        unique case (state_q)
            DISP_LIVE: begin
                if (!peek_n)          state_next = DISP_PEEK;
                else if (done_rise_c) state_next = DISP_RESULT;
            end
            DISP_PEEK: begin
                if (peek_n)           state_next = done ? DISP_RESULT : DISP_LIVE;
            end
            DISP_RESULT: begin
                if (!peek_n)          state_next = DISP_PEEK;
                else if (!done)       state_next = DISP_LIVE;
            end
            default:                  state_next = DISP_LIVE;
        endcase
    end

    // Display value chosen by the state being entered; on a done rise the
    // snapshot is loading this edge, so show reg_val directly.
    always_comb begin
        disp_val_c = '0;
        unique case (state_next)
            DISP_LIVE:   disp_val_c = reg_val;
            DISP_PEEK:   disp_val_c = (time_step == '0) ? '0 : bus;
            DISP_RESULT: disp_val_c = done_rise_c ? reg_val : snapshot_q;
            default:     disp_val_c = reg_val;
        endcase
    end

    assign disp_pad_c = PAD_W'(disp_val_c);
    assign time_pad_c = 4'(time_step);

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        hex7_seg_decoder u_dec (
            .nibble (disp_pad_c[4*k +: 4]),
            .seg_c  (seg_data_c[7*k +: 7])
        );
    end

    hex7_seg_decoder u_time_dec (
        .nibble (time_pad_c),
        .seg_c  (seg_time_c)
    );

    // Output and datapath registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            done_q     <= 1'b0;
            snapshot_q <= '0;
            led_bus    <= '0;
            hex_data   <= {NUM_DIGITS{SEG_BLANK}};
            hex_time   <= SEG_BLANK;
        end else begin
            done_q   <= done;
            led_bus  <= bus;
            hex_data <= seg_data_c;
            hex_time <= seg_time_c;
            if (done_rise_c) begin
                snapshot_q <= reg_val;
            end
        end
    end

`ifdef DONE_BLINK_EN
    localparam int unsigned BLINK_CNT_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    logic [BLINK_CNT_W-1:0] blink_cnt_q;

    // Blink: lit on the cycle after done rises, toggle every BLINK_HALF cycles
    always_ff @(posedge clk) begin
        if (!resetn) begin
            blink_cnt_q <= '0;
            led_done_n  <= 1'b1;
        end else if (!done) begin
            blink_cnt_q <= '0;
            led_done_n  <= 1'b1;
        end else if (done_rise_c) begin
            blink_cnt_q <= '0;
            led_done_n  <= 1'b0;
        end else if (blink_cnt_q == BLINK_CNT_W'(BLINK_HALF - 1)) begin
            blink_cnt_q <= '0;
            led_done_n  <= ~led_done_n;
        end else begin
            blink_cnt_q <= blink_cnt_q + 1'b1;
        end
    end
`else
    // Steady done LED
    always_ff @(posedge clk) begin
        if (!resetn) begin
            led_done_n <= 1'b1;
        end else begin
            led_done_n <= ~done;
        end
    end
`endif

endmodule

// File: tb/tb_display_output_ctrl.sv
// Directed bench for display_output_ctrl (DATA_W=10, TIME_W=2, BLINK_HALF=4).
module tb_display_output_ctrl;

    logic        clk;
    logic        resetn;
    logic [9:0]  bus;
    logic [9:0]  reg_val;
    logic [1:0]  time_step;
    logic        peek_n;
    logic        done;
    logic [9:0]  led_bus;
    logic [20:0] hex_data;
    logic [6:0]  hex_time;
    logic        led_done_n;
    logic [1:0]  mode;

    int n_checks = 0;
    int n_pass   = 0;

    localparam logic [1:0] M_LIVE = 2'd0, M_PEEK = 2'd1, M_RESULT = 2'd2;

    // Active-low glyphs, a = bit0
    localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30,
                           S5 = 7'h12, S7 = 7'h78, SA = 7'h08, SB = 7'h03,
                           SC = 7'h46, SF = 7'h0E, SBLK = 7'h7F;

    display_output_ctrl #(
        .DATA_W     (10),
        .TIME_W     (2),
        .BLINK_HALF (4)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .bus        (bus),
        .reg_val    (reg_val),
        .time_step  (time_step),
        .peek_n     (peek_n),
        .done       (done),
        .led_bus    (led_bus),
        .hex_data   (hex_data),
        .hex_time   (hex_time),
        .led_done_n (led_done_n),
        .mode       (mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [20:0] digits(input logic [6:0] d2, input logic [6:0] d1,
                                           input logic [6:0] d0);
        return {d2, d1, d0};
    endfunction

    // One clock edge; inputs change and outputs are sampled on the falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        resetn    = 1'b0;
        bus       = 10'($urandom);
        reg_val   = 10'($urandom);
        time_step = 2'($urandom);
        peek_n    = 1'($urandom);
        done      = 1'($urandom);
        for (int i = 0; i < 3; i++) begin
            step();
            bus       = 10'($urandom);
            reg_val   = 10'($urandom);
            time_step = 2'($urandom);
            peek_n    = 1'($urandom);
            done      = 1'($urandom);
        end
        check("rst_hex_data", 32'(hex_data), 32'(digits(SBLK, SBLK, SBLK)));
        check("rst_hex_time", 32'(hex_time), 32'(SBLK));
        check("rst_led_bus",  32'(led_bus), 32'd0);
        check("rst_led_done", 32'(led_done_n), 32'd1);
        check("rst_mode",     32'(mode), 32'(M_LIVE));

        // LIVE shows reg_val, led_bus follows bus
        resetn = 1'b1; peek_n = 1'b1; done = 1'b0;
        reg_val = 10'h2A5; bus = 10'h3FF; time_step = 2'd1;
        step();
        check("live_mode",     32'(mode), 32'(M_LIVE));
        check("live_hex_data", 32'(hex_data), 32'(digits(S2, SA, S5)));
        check("live_led_bus",  32'(led_bus), 32'h3FF);
        check("live_hex_time", 32'(hex_time), 32'(S1));
        check("live_led_done", 32'(led_done_n), 32'd1);

        // PEEK: bus forced to zero at timestep 0
        peek_n = 1'b0; bus = 10'h155; time_step = 2'd0;
        step();
        check("peek_mode",      32'(mode), 32'(M_PEEK));
        check("peek_ts0_data",  32'(hex_data), 32'(digits(S0, S0, S0)));
        check("peek_ts0_time",  32'(hex_time), 32'(S0));
        time_step = 2'd2;
        step();
        check("peek_ts2_data",  32'(hex_data), 32'(digits(S1, S5, S5)));
        check("peek_ts2_time",  32'(hex_time), 32'(S2));

        // RESULT holds the snapshot taken at done rise
        peek_n = 1'b1; done = 1'b0; reg_val = 10'h07C;
        step();
        check("back_live_mode", 32'(mode), 32'(M_LIVE));
        check("back_live_data", 32'(hex_data), 32'(digits(S0, S7, SC)));
        done = 1'b1;
        step();
        check("result_mode",     32'(mode), 32'(M_RESULT));
        check("result_data",     32'(hex_data), 32'(digits(S0, S7, SC)));
        check("result_led_done", 32'(led_done_n), 32'd0);
        reg_val = 10'h001;
        step();
        check("result_hold_mode", 32'(mode), 32'(M_RESULT));
        check("result_hold_data", 32'(hex_data), 32'(digits(S0, S7, SC)));
        done = 1'b0;
        step();
        check("done_fall_mode", 32'(mode), 32'(M_LIVE));
        check("done_fall_data", 32'(hex_data), 32'(digits(S0, S0, S1)));
        check("done_fall_led",  32'(led_done_n), 32'd1);

        // Peek and done rise together: PEEK wins, snapshot still taken
        reg_val = 10'h0F0; peek_n = 1'b0; done = 1'b1; bus = 10'h3AB; time_step = 2'd3;
        step();
        check("both_mode", 32'(mode), 32'(M_PEEK));
        check("both_data", 32'(hex_data), 32'(digits(S3, SA, SB)));
        reg_val = 10'h111; peek_n = 1'b1;
        step();
        check("release_mode", 32'(mode), 32'(M_RESULT));
        check("release_data", 32'(hex_data), 32'(digits(S0, SF, S0)));

        // done falls during PEEK; release returns to LIVE
        peek_n = 1'b0;
        step();
        done = 1'b0;
        step();
        check("peek_fall_mode", 32'(mode), 32'(M_PEEK));
        peek_n = 1'b1;
        step();
        check("peek_rel_mode", 32'(mode), 32'(M_LIVE));
        check("peek_rel_data", 32'(hex_data), 32'(digits(S1, S1, S1)));

        // Reset mid-operation with done held high gives a rise after reset
        done = 1'b1; reg_val = 10'h2A5;
        step();
        check("pre_rst_mode", 32'(mode), 32'(M_RESULT));
        resetn = 1'b0;
        step();
        check("mid_rst_data", 32'(hex_data), 32'(digits(SBLK, SBLK, SBLK)));
        check("mid_rst_mode", 32'(mode), 32'(M_LIVE));
        resetn = 1'b1; reg_val = 10'h155;
        step();
        check("post_rst_mode", 32'(mode), 32'(M_RESULT));
        check("post_rst_data", 32'(hex_data), 32'(digits(S1, S5, S5)));

        // Done LED over a long done pulse
        done = 1'b0;
        step();
        check("led_idle", 32'(led_done_n), 32'd1);
        done = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
`ifdef DONE_BLINK_EN
            check($sformatf("blink_%0d", i), 32'(led_done_n), ((i / 4) % 2 == 1) ? 32'd1 : 32'd0);
`else
            check($sformatf("steady_%0d", i), 32'(led_done_n), 32'd0);
`endif
        end
        done = 1'b0;
        step();
        check("led_off", 32'(led_done_n), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
